// File: rtl/window_filter_mc.sv
// Multi-channel window filter: accumulates a WINDOW_SIZE x WINDOW_SIZE block of
// raster-order samples and produces per-channel mean, min, max or centre value.
module window_filter_mc #(
  parameter int WINDOW_SIZE = 5,
  parameter int CHANNELS    = 3,
  parameter int CH_W        = 8,
  parameter int DATA_WIDTH  = CHANNELS * CH_W
) (
  input  logic                  MFilt_CLK,
  input  logic                  MFilt_RST,
  input  logic                  MFilt_EN,
  input  logic [1:0]            MFilt_MODE,
  input  logic                  MFilt_MEMRDY,
  input  logic [DATA_WIDTH-1:0] MFilt_MEMDATA,
  output logic [DATA_WIDTH-1:0] MFilt_RES,
  output logic                  MFilt_DNE,
  output logic                  MFilt_BUSY
);

  localparam int N     = WINDOW_SIZE * WINDOW_SIZE;
  localparam int CNT_W = $clog2(N);
  localparam int SUM_W = CH_W + $clog2(N);

  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CENTRE_IDX = CNT_W'((N - 1) / 2);

  localparam logic [1:0] MODE_MEAN   = 2'b00;
  localparam logic [1:0] MODE_MIN    = 2'b01;
  localparam logic [1:0] MODE_MAX    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    CALC = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [1:0]                           mode_q, mode_d;
  logic [CHANNELS-1:0][SUM_W-1:0]       sum_q, sum_d;
  logic [CHANNELS-1:0][CH_W-1:0]        min_q, min_d;
  logic [CHANNELS-1:0][CH_W-1:0]        max_q, max_d;
  logic [CHANNELS-1:0][CH_W-1:0]        cent_q, cent_d;
  logic [DATA_WIDTH-1:0]                res_q, res_d;
  logic [CHANNELS-1:0][CH_W-1:0]        samp;

  assign samp = MFilt_MEMDATA[CHANNELS*CH_W-1:0];

  // Divisor is a constant, so this reduces to a fixed reciprocal network.
  function automatic logic [CH_W-1:0] mean_div(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] q;
    q = s / SUM_W'(N);
    return q[CH_W-1:0];
  endfunction

  always_ff @(posedge MFilt_CLK or posedge MFilt_RST) begin
    if (MFilt_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      cent_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cent_q  <= cent_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    cent_d  = cent_q;
    res_d   = res_q;

    case (state_q)
      IDLE, DONE: begin
        if (MFilt_EN) begin
          state_d = ACC;
          mode_d  = MFilt_MODE;
          cnt_d   = '0;
          sum_d   = '0;
          min_d   = '1;
          max_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (MFilt_MEMRDY) begin
          for (int c = 0; c < CHANNELS; c++) begin
            sum_d[c] = sum_q[c] + SUM_W'(samp[c]);
            if (samp[c] < min_q[c]) min_d[c] = samp[c];
            if (samp[c] > max_q[c]) max_d[c] = samp[c];
          end
          if (cnt_q == CENTRE_IDX) cent_d = samp;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = CALC;
        end
      end
      CALC: begin
        res_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
          case (mode_q)
            MODE_MEAN: res_d[c*CH_W +: CH_W] = mean_div(sum_q[c]);
            MODE_MIN:  res_d[c*CH_W +: CH_W] = min_q[c];
            MODE_MAX:  res_d[c*CH_W +: CH_W] = max_q[c];
            default:   res_d[c*CH_W +: CH_W] = cent_q[c];
          endcase
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MFilt_RES  = res_q;
  assign MFilt_DNE  = (state_q == DONE);
  assign MFilt_BUSY = (state_q != IDLE);

endmodule

// File: doc/window_filter_mc.md
WINDOW_FILTER_MC -- requirements
Module: window_filter_mc

Interface
REQ-001 SHALL have parameter WINDOW_SIZE, default 5: window side; odd, 3..9; N = WINDOW_SIZE*WINDOW_SIZE samples per window.
REQ-002 SHALL have parameter CHANNELS, default 3: independent unsigned channels per pixel word.
REQ-003 SHALL have parameter CH_W, default 8: bits per channel.
REQ-004 SHALL have parameter DATA_WIDTH, default CHANNELS*CH_W (24): pixel word width; channel c occupies bits [c*CH_W +: CH_W].
REQ-005 SHALL have port MFilt_CLK, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port MFilt_RST, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port MFilt_EN, input, 1: start-window request.
REQ-008 SHALL have port MFilt_MODE, input, 2: 00 mean, 01 min, 10 max, 11 centre pass-through; sampled with accepted EN.
REQ-009 SHALL have port MFilt_MEMRDY, input, 1: MFilt_MEMDATA valid this cycle.
REQ-010 SHALL have port MFilt_MEMDATA, input, DATA_WIDTH: window sample, raster order.
REQ-011 SHALL have port MFilt_RES, output, DATA_WIDTH: registered filter result.
REQ-012 SHALL have port MFilt_DNE, output, 1: result-valid pulse.
REQ-013 SHALL have port MFilt_BUSY, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, CALC, DONE.
REQ-015 IDLE or DONE with MFilt_EN=1 SHALL latch MODE, clear sample counter, sums to 0, min to all-ones, max to 0, and go to ACC; otherwise IDLE stays IDLE and DONE goes to IDLE.
REQ-016 MFilt_EN in ACC or CALC SHALL be ignored (no restart, no mode change).
REQ-017 In ACC, each cycle with MFilt_MEMRDY=1 SHALL consume one sample and increment the counter; MEMRDY=0 SHALL stall with no state change.
REQ-018 MFilt_MEMRDY in IDLE, CALC or DONE SHALL be ignored.
REQ-019 Acceptance of sample N-1 (0-based) SHALL move ACC to CALC at that edge.
REQ-020 Per channel SHALL maintain sum (width CH_W+clog2(N), no overflow), running min, running max, unsigned.
REQ-021 Sample index (N-1)/2 SHALL be captured as the centre sample.
REQ-022 CALC SHALL register MFilt_RES per channel: mean = floor(sum/N); min; max; or centre sample, per latched mode, and go to DONE.
REQ-023 MFilt_DNE SHALL be high exactly the one cycle in DONE; i.e. rises on the second edge after the edge accepting the last sample.
REQ-024 MFilt_RES SHALL hold its value until the next CALC.
REQ-025 EN accepted in DONE SHALL give back-to-back windows with DNE still pulsing that cycle.
REQ-026 Channels SHALL never interact (no carry/borrow across channel boundaries).

Reset
REQ-027 MFilt_RST=1 SHALL immediately force IDLE, MFilt_RES=0, MFilt_DNE=0, MFilt_BUSY=0, counter/sums/min/max/centre/mode cleared.
REQ-028 Reset mid-window SHALL discard the partial window; no DNE until a new EN and N further samples.
REQ-029 First EN after reset release SHALL be honoured on the first rising edge with MFilt_RST=0.

Verification (WINDOW_SIZE=3, CHANNELS=3, CH_W=8)
REQ-030 Mean flat: MODE=00, 9 samples 0x102030, MEMRDY=1 continuous -> RES=0x102030, DNE one cycle, two edges after ninth sample, BUSY low after.
REQ-031 Mean truncation/width: MODE=00, samples 0xFF0009 x8 plus 0xFF0001 -> sums 0x8F7,0,0x49 -> RES=0xFF0008 (73/9=8), no channel bleed.
REQ-032 Min/max: samples c2,c1,c0 = (i, 8-i, 0x80) for i=0..8; MODE=01 -> RES=0x000080; repeat MODE=10 -> RES=0x080880; MODE=11 -> RES=0x040480.
REQ-033 Stall: MEMRDY alternating 1/0 across 9 samples, EN pulsed mid-window -> identical RES to continuous case, DNE after 9th accepted sample only, no restart.
REQ-034 Reset mid-op: assert MFilt_RST after 5 samples -> RES=0, BUSY=0 same cycle; new EN + 9 samples 0x010203 MODE=00 -> RES=0x010203.
REQ-035 Back-to-back: EN held high through DONE -> second window starts, two DNE pulses separated by exactly 11 cycles with continuous MEMRDY.
